// File: rtl/booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_seq_ctrl
//
// Sequential radix-2 Booth multiplier with a valid/ready handshake on both
// sides. One shared W+1-bit add/sub and one arithmetic right shift happen per
// RUN cycle. There is no parallel multiplier.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   in_valid     operand pair present
//   in_ready     block accepts operands this cycle (state IDLE)
//   in_a         multiplicand, signed two's complement, W bits
//   in_b         multiplier, signed two's complement, W bits
//   out_valid    product available (state DONE)
//   out_ready    consumer takes the product this cycle
//   out_product  signed product in_a*in_b, 2W bits, held between results
//   busy         high in RUN or DONE
//
// Configuration macro
//   BOOTH_ZERO_SKIP_EN  when defined, an accepted pair with a zero operand
//                       skips the iterations and delivers 0 one cycle after
//                       the accept. When undefined, every operation runs all
//                       W iterations.
// ---------------------------------------------------------------------------
module booth_seq_ctrl #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           busy
);

  // Counter must be able to hold the value W itself.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(W);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [W:0]       a_q, a_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*W-1:0]   product_q, product_d;

  logic [W:0]       addend_s;
  logic             cin_s;
  logic [W:0]       sum_s;
  logic             zero_skip_s;

  // Booth recode of {Q[0], q_m1}: the single shared add/sub of this cycle.
  // Subtraction is the one's complement of sext(M) with a carry-in of 1; the
  // extra top bit keeps M = -2^(W-1) from overflowing.
  always_comb begin
    addend_s = {(W+1){1'b0}};
    cin_s    = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01: begin
        addend_s = {m_q[W-1], m_q};
        cin_s    = 1'b0;
      end
      2'b10: begin
        addend_s = ~{m_q[W-1], m_q};
        cin_s    = 1'b1;
      end
      default: begin
        addend_s = {(W+1){1'b0}};
        cin_s    = 1'b0;
      end
    endcase
    sum_s = a_q + addend_s + {{W{1'b0}}, cin_s};
  end

  // Zero-operand detection for the optional shortcut.
`ifdef BOOTH_ZERO_SKIP_EN
  always_comb begin
    zero_skip_s = (in_a == {W{1'b0}}) || (in_b == {W{1'b0}});
  end
`else
  always_comb begin
    zero_skip_s = 1'b0;
  end
`endif

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    a_d       = a_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          m_d     = in_a;
          q_d     = in_b;
          qm1_d   = 1'b0;
          a_d     = {(W+1){1'b0}};
          if (zero_skip_s) begin
            // Zero shortcut: Q and A are cleared and the counter is preset to
            // its final value, so the next edge moves to DONE with a product
            // of 0, one cycle after the accept.
            q_d     = {W{1'b0}};
            count_d = COUNT_LAST;
          end else begin
            count_d = {CW{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_q == COUNT_LAST) begin
          // All W iterations are done; capture the low 2W bits of {A,Q}.
          state_d   = ST_DONE;
          product_d = {a_q[W-1:0], q_q};
        end else begin
          // Arithmetic right shift of {A,Q,q_m1} after the add/sub.
          a_d     = {sum_s[W], sum_s[W:1]};
          q_d     = {sum_s[0], q_q[W-1:1]};
          qm1_d   = q_q[0];
          count_d = count_q + COUNT_ONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= {W{1'b0}};
      q_q       <= {W{1'b0}};
      qm1_q     <= 1'b0;
      a_q       <= {(W+1){1'b0}};
      count_q   <= {CW{1'b0}};
      product_q <= {(2*W){1'b0}};
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      a_q       <= a_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_ctrl
//
// Directed bench for booth_seq_ctrl (W=32). A transaction-level model keeps
// the expected handshake phase and product (signed multiply in plain
// arithmetic plus a latency countdown). One process compares every output on
// every falling edge, and the directed vectors also check hand-computed
// products and latencies.
// ---------------------------------------------------------------------------
module tb_booth_seq_ctrl;

  localparam int W = 32;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_product;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic int op_latency(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'd0 || b == 32'd0) return ZERO_LAT;
    return W + 1;
  endfunction

  // phase: 0 = waiting for operands, 1 = computing, 2 = result offered
  int          mdl_phase = 0;
  int          mdl_left  = 0;
  logic [63:0] mdl_pend  = 64'd0;
  logic [63:0] mdl_prod  = 64'd0;
  logic        mdl_en    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_phase <= 0;
      mdl_left  <= 0;
      mdl_prod  <= 64'd0;
      mdl_en    <= 1'b1;
    end else begin
      case (mdl_phase)
        0: if (in_valid) begin
             mdl_pend  <= smul(in_a, in_b);
             mdl_left  <= op_latency(in_a, in_b);
             mdl_phase <= 1;
           end
        1: if (mdl_left == 1) begin
             mdl_phase <= 2;
             mdl_prod  <= mdl_pend;
           end else begin
             mdl_left <= mdl_left - 1;
           end
        2: if (out_ready) mdl_phase <= 0;
        default: mdl_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      chk("in_ready",    {63'd0, in_ready},  {63'd0, mdl_phase == 0});
      chk("out_valid",   {63'd0, out_valid}, {63'd0, mdl_phase == 2});
      chk("busy",        {63'd0, busy},      {63'd0, mdl_phase != 0});
      chk("out_product", out_product,        mdl_prod);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid(output bit ok);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      in_a = $urandom;
      in_b = $urandom;
      k++;
    end
    ok = out_valid;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: out_valid not seen within 100 cycles");
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int hold, input int exp_lat);
    int t_acc;
    bit ok;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    t_acc = cyc;
    chk("accept_busy", {63'd0, busy}, 64'd1);
    // in_valid stays high and operands wander while busy: must be ignored.
    wait_valid(ok);
    in_valid = 1'b0;
    if (ok) begin
      chk("latency", 64'(cyc - t_acc), 64'(exp_lat));
      chk("product", out_product, exp);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid",    {63'd0, out_valid}, 64'd1);
        chk("hold_product",  out_product, exp);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("deliver_in_ready",  {63'd0, in_ready},  64'd1);
      chk("deliver_out_valid", {63'd0, out_valid}, 64'd0);
      chk("deliver_product",   out_product, exp);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_product",   out_product,        64'd0);
    rst = 1'b0;

    do_op(32'd3,          32'd4,          64'h0000_0000_0000_000C, 0, 33);
    do_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 0, 33);
    do_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001, 0, 33);
    do_op(32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 5, 33);
    do_op(32'h8000_0000,  32'h0000_0001,  64'hFFFF_FFFF_8000_0000, 2, 33);
    do_op(32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0, 33);
    do_op(32'h0000_0000,  32'h0000_1234,  64'h0000_0000_0000_0000, 1, ZERO_LAT);
    do_op(32'h0000_0006,  32'h0000_0000,  64'h0000_0000_0000_0000, 0, ZERO_LAT);

    // Abort in RUN at count=10: accepted at edge T, count is 10 after T+10.
    @(negedge clk);
    in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  {63'd0, in_ready},  64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    do_op(32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD, 0, 33);

    // Reset in DONE together with out_ready: reset wins, result discarded.
    @(negedge clk);
    in_a = 32'd2; in_b = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    wait_valid(ok);
    in_valid = 1'b0;
    if (ok) begin
      chk("done_product", out_product, 64'd6);
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      chk("rst_done_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_done_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_done_product",   out_product,        64'd0);
    end

    do_op(32'hFFFF_FFF0, 32'h0000_0010, 64'hFFFF_FFFF_FFFF_FF00, 0, 33);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
